// File: rtl/fc_argmax.sv
// Serial argmax over a vector of binary16 scores, one score per enabled clock.
// Result is sticky in DONE until reset; uses the FC-layer enable/finished handshake.
//
// state | meaning
// IDLE  | waiting for enable; first enabled edge loads node 0
// SCAN  | comparing node i against the running maximum
// DONE  | result valid and frozen until reset
module fc_argmax #(
   parameter int numClasses = 10,
   parameter int IDXW       = $clog2(numClasses)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic [15:0]     inputNodes [0:numClasses-1],
   output logic [IDXW-1:0] classIndex,
   output logic [15:0]     maxValue,
   output logic            finished
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } stateType;

   localparam logic [IDXW:0] lastIdx = (IDXW+1)'(numClasses - 1);

   stateType        state;
   stateType        nextState;
   logic [IDXW:0]   i;
   logic [15:0]     candidate;
   logic            candWins;
   logic            atLast;

   function automatic logic isNaN(input logic [15:0] v);
      return (v[14:10] == 5'h1F) && (v[9:0] != 10'h000);
   endfunction

   // Monotonic unsigned key: negatives inverted below positives, -0 folded onto +0.
   function automatic logic [15:0] orderKey(input logic [15:0] v);
      logic [15:0] z;
      z = (v == 16'h8000) ? 16'h0000 : v;
      return z[15] ? {1'b0, ~z[14:0]} : {1'b1, z[14:0]};
   endfunction

   always_comb begin
      candidate = inputNodes[i[IDXW-1:0]];
      candWins  = !isNaN(candidate) &&
                  (isNaN(maxValue) || (orderKey(candidate) > orderKey(maxValue)));
      atLast    = (i == lastIdx);
      nextState = state;
      case (state)
         IDLE:    if (enable) nextState = SCAN;
         SCAN:    if (enable && atLast) nextState = DONE;
         DONE:    nextState = DONE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         classIndex <= '0;
         maxValue   <= 16'h0000;
         finished   <= 1'b0;
         i          <= '0;
      end else if (enable) begin
         case (state)
            IDLE: begin
               maxValue   <= inputNodes[0];
               classIndex <= '0;
               i          <= (IDXW+1)'(1);
            end
            SCAN: begin
               if (candWins) begin
                  maxValue   <= candidate;
                  classIndex <= i[IDXW-1:0];
               end
               if (atLast) finished <= 1'b1;
               else        i        <= i + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_argmax.sv
// Randomized scoreboard bench for fc_argmax: stimulus pushes expected results,
// a negedge monitor pops and checks on each rising finished.
module tb_fc_argmax;
   localparam int N  = 10;
   localparam int IW = $clog2(N);

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [15:0]   nodes [0:N-1];
   logic [IW-1:0] classIndex;
   logic [15:0]   maxValue;
   logic          finished;

   typedef struct {
      int idx;
      int val;
      int finEdge;
   } expType;

   expType expQ[$];
   int     checks = 0;
   int     errors = 0;
   int     cycleCnt = 0;
   int     lastIdx, lastVal;
   logic   prevFin = 1'b0;

   fc_argmax #(.numClasses(N)) dut (
      .clk(clk), .reset(reset), .enable(enable), .inputNodes(nodes),
      .classIndex(classIndex), .maxValue(maxValue), .finished(finished)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycleCnt++;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit h16NaN(input logic [15:0] b);
      return (b[14:10] == 5'h1F) && (b[9:0] != 0);
   endfunction

   // Numeric value of a non-NaN binary16 pattern; infinity as a huge real.
   function automatic real h16Real(input logic [15:0] b);
      int  e;
      int  m;
      real mag;
      e = int'(b[14:10]);
      m = int'(b[9:0]);
      if (e == 0)       mag = real'(m) * (2.0 ** (-24));
      else if (e == 31) mag = 1.0e300;
      else              mag = real'(1024 + m) * (2.0 ** (e - 25));
      return b[15] ? -mag : mag;
   endfunction

   task automatic refModel(output int idx, output int val);
      int best = 0;
      for (int k = 1; k < N; k++) begin
         if (h16NaN(nodes[k])) continue;
         if (h16NaN(nodes[best]) || (h16Real(nodes[k]) > h16Real(nodes[best]))) best = k;
      end
      idx = best;
      val = int'(nodes[best]);
   endtask

   function automatic logic [15:0] randHalf();
      logic [15:0] pool [0:11];
      pool = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'hFE00,
               16'h7C01, 16'h0001, 16'h8001, 16'h3C00, 16'hBC00, 16'h03FF};
      case ($urandom_range(0, 2))
         0:       return 16'($urandom);
         1:       return pool[$urandom_range(0, 11)];
         default: return 16'h3C00 + 16'($urandom_range(0, 3));
      endcase
   endfunction

   always @(negedge clk) begin
      if (finished && !prevFin) begin
         if (expQ.size() == 0) chk("unexpected_finish", 1, 0);
         else begin
            expType e;
            e = expQ.pop_front();
            chk("classIndex", int'(classIndex), e.idx);
            chk("maxValue", int'(maxValue), e.val);
            chk("latency_edge", cycleCnt, e.finEdge);
         end
      end
      prevFin = finished;
   end

   task automatic doReset();
      reset  = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      reset  = 1'b0;
   endtask

   // Starts from IDLE at a negedge; optional enable gap of gapLen cycles after gapAt enabled edges.
   task automatic runScan(input int gapAt, input int gapLen);
      expType e;
      int     edgesDone = 0;
      int     gapCnt = 0;
      bit     seen = 0;
      refModel(e.idx, e.val);
      e.finEdge = cycleCnt + 1 + (N - 1) + gapLen;
      lastIdx = e.idx;
      lastVal = e.val;
      expQ.push_back(e);
      enable = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (enable) edgesDone++;
         if (finished) begin
            seen = 1;
            break;
         end
         if (gapLen > 0 && edgesDone == gapAt && gapCnt < gapLen) begin
            enable = 1'b0;
            gapCnt++;
         end else enable = 1'b1;
      end
      if (!seen) chk("finish_timeout", 0, 1);
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      for (int k = 0; k < N; k++) nodes[k] = 16'h0000;
      repeat (2) @(negedge clk);
      doReset();
      chk("reset_classIndex", int'(classIndex), 0);
      chk("reset_maxValue", int'(maxValue), 0);
      chk("reset_finished", int'(finished), 0);

      for (int k = 0; k < N; k++) nodes[k] = 16'h3C00;
      nodes[7] = 16'h4000;
      runScan(0, 0);
      chk("distinct_idx_const", lastIdx, 7);

      // hold in DONE while enable toggles and the vector changes
      for (int c = 0; c < 6; c++) begin
         enable = 1'($urandom);
         for (int k = 0; k < N; k++) nodes[k] = 16'($urandom);
         @(negedge clk);
         chk("hold_finished", int'(finished), 1);
         chk("hold_classIndex", int'(classIndex), 7);
         chk("hold_maxValue", int'(maxValue), 16'h4000);
      end

      doReset();
      for (int k = 0; k < N; k++) nodes[k] = 16'hC000;
      nodes[0] = 16'h8000;
      nodes[3] = 16'h0000;
      runScan(0, 0);

      doReset();
      for (int k = 0; k < N; k++) nodes[k] = 16'h0000;
      nodes[2] = 16'h4200;
      nodes[5] = 16'h4200;
      runScan(0, 0);

      doReset();
      for (int k = 0; k < N; k++) nodes[k] = 16'hFE00;
      nodes[0] = 16'h7E00;
      nodes[4] = 16'hFC00;
      runScan(0, 0);

      doReset();
      for (int k = 0; k < N; k++) nodes[k] = (k % 2 == 0) ? 16'hFE00 : 16'h7C01;
      nodes[0] = 16'h7E00;
      runScan(0, 0);

      doReset();
      for (int k = 0; k < N; k++) nodes[k] = 16'h3C00 + 16'($urandom_range(0, 255));
      nodes[9] = 16'h7C00;
      runScan(4, 3);

      // reset mid-scan: abort after 4 enabled edges, swap vector during reset
      doReset();
      for (int k = 0; k < N; k++) nodes[k] = randHalf();
      enable = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < N; k++) nodes[k] = randHalf();
      @(negedge clk);
      chk("midreset_classIndex", int'(classIndex), 0);
      chk("midreset_maxValue", int'(maxValue), 0);
      chk("midreset_finished", int'(finished), 0);
      reset = 1'b0;
      runScan(0, 0);

      for (int t = 0; t < 20; t++) begin
         doReset();
         for (int k = 0; k < N; k++) nodes[k] = randHalf();
         if ($urandom_range(0, 1) == 1) runScan($urandom_range(1, N - 1), $urandom_range(1, 4));
         else                           runScan(0, 0);
      end

      @(negedge clk);
      chk("queue_drained", expQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end
endmodule

// File: doc/fc_argmax.md
# fc_argmax

Classification stage placed directly downstream of the final fully-connected layer. It accepts that layer's `outputNodes` vector of IEEE-754 binary16 scores and scans it serially, one score per cycle. It reports the index and value of the largest score and raises `finished`. It uses the same enable/finished handshake as the FC layers, so its `enable` is driven from the FC layer's `finished`.

## Interface
- `numClasses`, default 10: number of scores in the vector; legal range is 2 to 1024.
- `IDXW`, default `$clog2(numClasses)`: width of `classIndex`. Derived; do not override.

- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: reset is synchronous and active-high.
- `enable` input, 1 bit: level-sensitive run. The block advances only on edges where `enable`=1.
- `inputNodes` input, [15:0] × `numClasses` (unpacked `[0:numClasses-1]`): binary16 scores. Must remain stable from the first enabled edge until `finished`.
- `classIndex` output, `IDXW` bits (reg): index of the winning score.
- `maxValue` output, [15:0] (reg): binary16 bit pattern of the winning score.
- `finished` output, 1 bit (reg): result valid. Sticky until `reset`.

## Operation
- States are IDLE, SCAN and DONE. Internal counter `i` is `IDXW`+1 bits.
- **reset=1.** Takes priority over everything, including `enable`. Next state is IDLE, `classIndex`=0, `maxValue`=16'h0000, `finished`=0, `i`=0.
- **IDLE with enable=1.**
  - `maxValue` ← `inputNodes[0]`, `classIndex` ← 0, `i` ← 1.
  - Go to SCAN.
- **SCAN with enable=1.**
  - Compare `c = inputNodes[i]` against `maxValue`.
  - If `c` wins, `maxValue` ← `c` and `classIndex` ← `i`.
  - If `i == numClasses-1`, go to DONE and set `finished` ← 1 on the same edge. Otherwise `i` ← `i`+1.
- **enable=0 in any state.** All registers hold; a scan in progress pauses and resumes on the next enabled edge.
- **DONE.** All outputs hold regardless of `enable`. Only `reset` leaves DONE.
- **Win rule.** Comparison is done in-block on raw bits, with no arithmetic unit.
  - NaN means exp=5'h1F and mantissa≠0. A NaN candidate never wins.
  - If `maxValue` is NaN, any non-NaN candidate wins.
  - Otherwise the candidate wins only if it is strictly greater in binary16 order.
  - ±Inf order normally. Subnormals order by magnitude. +0 and −0 compare equal.
  - Ties keep the lower index, because there is no replacement on equality.
- **Ordering implementation.** Map each value to an unsigned key:
  - Sign 0: key = {1'b1, bits[14:0]}.
  - Sign 1: key = {1'b0, ~bits[14:0]}.
  - Before mapping, force −0 to +0.
  - Compare keys unsigned.
- **All-NaN input.** Result is index 0, with `maxValue` equal to `inputNodes[0]`'s pattern.

## Timing
- Latency is exactly `numClasses` enabled edges from IDLE to `finished`=1. Edge 1 loads node 0; edges 2..N compare nodes 1..N−1.
- `finished`, `classIndex` and `maxValue` change on the same edge. The final result is registered and glitch-free from that edge onward.
- Throughput is one result per reset. A new vector requires pulsing `reset` for one cycle.
- **Reset mid-SCAN.** Partial results are discarded and outputs return to their reset values on that edge. If `enable` is still high, a fresh scan starts on the next edge.
- **Reset and enable on the same edge.** Reset wins; no load happens.
- Outputs are undefined to the consumer while `finished`=0; only the reset values are guaranteed.

## Test plan
- **Distinct values.** N=10, all nodes 16'h3C00 (1.0) except node 7 = 16'h4000 (2.0); hold enable. Required: `finished` rises on edge 10, `classIndex`=7, `maxValue`=16'h4000.
- **Ties and signed zero.**
  - Case 1: node 0 = 16'h8000 (−0), node 3 = 16'h0000 (+0), all others 16'hC000 (−2.0). Required: index 0, value 16'h8000.
  - Case 2: nodes 2 and 5 = 16'h4200. Required: index 2.
- **NaN handling.** Node 0 = 16'h7E00, node 4 = 16'hFC00 (−Inf), all others 16'hFE00. Required: index 4, value 16'hFC00. With all nodes NaN: index 0, value 16'h7E00.
- **Enable gaps.** Drop `enable` for 3 cycles after edge 4 of the scan with the winner at node 9 = 16'h7C00 (+Inf). Required: `finished` rises 13 clocks after start, `classIndex`=9.
- **Reset mid-scan.** Assert `reset` for 1 cycle at edge 5 while `enable`=1, and change the vector during the reset cycle. Required: outputs are 0/0/0 after the reset edge. A full new scan then completes 10 edges later with the new vector's argmax.
- **Hold in DONE.** After `finished`, toggle `enable` and change `inputNodes`. Required: all outputs remain unchanged.
